// File: rtl/flash_ctrl_pkg.sv
// Shared register map, command codes and enums for the Avalon-MM flash host.
package flash_ctrl_pkg;

  localparam logic [3:0] REG_ADDR_HI = 4'h1;
  localparam logic [3:0] REG_ADDR_LO = 4'h2;
  localparam logic [3:0] REG_WDATA   = 4'h3;
  localparam logic [3:0] REG_RDATA   = 4'h4;
  localparam logic [3:0] REG_CMD     = 4'h6;

  localparam logic [15:0] CMD_READ    = 16'd2;
  localparam logic [15:0] CMD_PROGRAM = 16'd3;
  localparam logic [15:0] CMD_ERASE   = 16'd4;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AHI,
    ST_WR_ALO,
    ST_WR_DATA,
    ST_WR_CMD,
    ST_WAIT_IRQ,
    ST_RD_DATA,
    ST_RESP
  } state_e;

  function automatic logic [15:0] cmd_code(input op_e op);
    case (op)
      OP_READ:    cmd_code = CMD_READ;
      OP_PROGRAM: cmd_code = CMD_PROGRAM;
      default:    cmd_code = CMD_ERASE;
    endcase
  endfunction

endpackage

// File: rtl/flash_tmo_cnt.sv
// WAIT_IRQ timeout counter: clears while idle, counts while enabled, flags the last allowed cycle.
module flash_tmo_cnt #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000,
  parameter int unsigned TW             = 22
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 32'd1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/flash_avl_host.sv
// Sequences user READ/PROGRAM/ERASE requests into Avalon-MM register accesses on a flash controller.
module flash_avl_host
  import flash_ctrl_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000,
  parameter int unsigned TW             = 22
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [22:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [3:0]  avm_addr_o,
  output logic [15:0] avm_wdata_o,
  output logic        avm_write_o,
  output logic        avm_read_o,
  output logic        avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [15:0] avm_rdata_i,
  input  logic [1:0]  irq_i
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  avm_addr_q, avm_addr_d;
  logic [15:0] avm_wdata_q, avm_wdata_d;
  logic        avm_write_q, avm_write_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_be_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        tmo_expire;

  flash_tmo_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q != ST_WAIT_IRQ),
    .en_i    (state_q == ST_WAIT_IRQ),
    .expire_o(tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_err_d  = 1'b0;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d    = op_e'(req_op_i);
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (op_e'(req_op_i) == OP_RSVD) begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = ST_WR_AHI;
          end
        end
      end
      ST_WR_AHI:  if (!avm_waitrequest_i) state_d = ST_WR_ALO;
      ST_WR_ALO:  if (!avm_waitrequest_i) state_d = (op_q == OP_PROGRAM) ? ST_WR_DATA : ST_WR_CMD;
      ST_WR_DATA: if (!avm_waitrequest_i) state_d = ST_WR_CMD;
      ST_WR_CMD:  if (!avm_waitrequest_i) state_d = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        // Error irq outranks done; the timeout only fires when neither is present.
        if (irq_i[1] || (!irq_i[0] && tmo_expire)) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (irq_i[0]) begin
          if (op_q == OP_READ) begin
            state_d = ST_RD_DATA;
          end else begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
          end
        end
      end
      ST_RD_DATA: begin
        if (!avm_waitrequest_i) begin
          state_d    = ST_RESP;
          rsp_data_d = avm_rdata_i;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are registered, so decode them from the state being entered.
    avm_write_d = 1'b0;
    avm_read_d  = 1'b0;
    avm_addr_d  = '0;
    avm_wdata_d = '0;
    case (state_d)
      ST_WR_AHI: begin
        avm_write_d = 1'b1;
        avm_addr_d  = REG_ADDR_HI;
        avm_wdata_d = {9'd0, addr_d[22:16]};
      end
      ST_WR_ALO: begin
        avm_write_d = 1'b1;
        avm_addr_d  = REG_ADDR_LO;
        avm_wdata_d = addr_d[15:0];
      end
      ST_WR_DATA: begin
        avm_write_d = 1'b1;
        avm_addr_d  = REG_WDATA;
        avm_wdata_d = wdata_d;
      end
      ST_WR_CMD: begin
        avm_write_d = 1'b1;
        avm_addr_d  = REG_CMD;
        avm_wdata_d = cmd_code(op_d);
      end
      ST_RD_DATA: begin
        avm_read_d = 1'b1;
        avm_addr_d = REG_RDATA;
      end
      default: ;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      avm_addr_q  <= '0;
      avm_wdata_q <= '0;
      avm_write_q <= 1'b0;
      avm_read_q  <= 1'b0;
      avm_be_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      avm_addr_q  <= avm_addr_d;
      avm_wdata_q <= avm_wdata_d;
      avm_write_q <= avm_write_d;
      avm_read_q  <= avm_read_d;
      avm_be_q    <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_data_o       = rsp_data_q;
  assign avm_addr_o       = avm_addr_q;
  assign avm_wdata_o      = avm_wdata_q;
  assign avm_write_o      = avm_write_q;
  assign avm_read_o       = avm_read_q;
  assign avm_byteenable_o = avm_be_q;

endmodule

// File: doc/flash_avl_host.md
FLASH_AVL_HOST -- requirements
Module: flash_avl_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd3000000, max cycles in WAIT_IRQ before error.
REQ-002 SHALL have parameter TW, default 22, timeout counter width; TIMEOUT_CYCLES SHALL fit in TW bits.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  in  1  user request valid.
REQ-006 SHALL have port req_ready_o  out  1  block accepts request.
REQ-007 SHALL have port req_op_i  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=reserved.
REQ-008 SHALL have port req_addr_i  in  23  flash word address.
REQ-009 SHALL have port req_wdata_i  in  16  program data.
REQ-010 SHALL have port rsp_valid_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_data_o  out  16  read data; 0 for non-READ or error.
REQ-012 SHALL have port rsp_err_o  out  1  error flag, valid with rsp_valid_o.
REQ-013 SHALL have ports avm_addr_o out 4, avm_wdata_o out 16, avm_write_o out 1, avm_read_o out 1, avm_byteenable_o out 1: Avalon-MM host outputs to the flash controller slave.
REQ-014 SHALL have ports avm_waitrequest_i in 1, avm_rdata_i in 16, irq_i in 2 (bit0 done, bit1 error): controller responses.

Function
REQ-015 Register map SHALL be: 0x1 ADDR_HI (data[6:0]=addr[22:16]), 0x2 ADDR_LO (addr[15:0]), 0x3 WDATA, 0x4 RDATA, 0x6 CMD (2=READ, 3=PROGRAM, 4=ERASE).
REQ-016 FSM states SHALL be IDLE, WR_AHI, WR_ALO, WR_DATA, WR_CMD, WAIT_IRQ, RD_DATA, RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i & req_ready_o; op/addr/wdata captured that cycle.
REQ-018 Accepted op 3 SHALL go to RESP directly with rsp_err_o=1, no bus activity.
REQ-019 Sequence SHALL be WR_AHI -> WR_ALO -> WR_DATA (PROGRAM only) -> WR_CMD -> WAIT_IRQ.
REQ-020 In each WR_* state avm_write_o=1 with stable addr/data; state advances in the cycle avm_waitrequest_i=0.
REQ-021 avm_byteenable_o SHALL be 1 always (16-bit word mode); ADDR_HI data[15:7]=0.
REQ-022 avm_write_o and avm_read_o SHALL never be 1 together; both 0 outside WR_*/RD_DATA.
REQ-023 WAIT_IRQ: irq_i[1]=1 -> RESP, err=1 (error wins if both bits set); else irq_i[0]=1 -> RD_DATA for READ, RESP err=0 otherwise.
REQ-024 Timeout counter SHALL clear on WAIT_IRQ entry, increment per WAIT_IRQ cycle; at TIMEOUT_CYCLES-1 without irq -> RESP, err=1.
REQ-025 RD_DATA: avm_read_o=1, avm_addr_o=0x4; rdata captured in the cycle avm_waitrequest_i=0 (zero read latency), then RESP.
REQ-026 RESP lasts exactly one cycle with rsp_valid_o=1, then IDLE; no response backpressure.
REQ-027 rsp_data_o SHALL hold the last response value until the next RESP.
REQ-028 Minimum PROGRAM latency, accept to rsp_valid_o, with no waitrequest and irq on first WAIT_IRQ cycle: 6 cycles.

Reset
REQ-029 rst_i=1 SHALL force IDLE, all outputs 0 except req_ready_o (0 during reset, 1 first cycle after), timeout counter 0.
REQ-030 Reset mid-operation SHALL abort immediately: bus strobes drop next edge, no rsp_valid_o for the aborted request.

Structure
REQ-031 flash_ctrl_pkg SHALL hold register addresses, CMD codes, op enum and FSM state enum.
REQ-032 One sub-module, flash_tmo_cnt (clear/enable/expire, width TW), SHALL implement the timeout.

Verification
REQ-033 PROGRAM addr 0x000127 data 0xAE8, no wait -> writes (0x1,0x0),(0x2,0x127),(0x3,0xAE8),(0x6,0x3); irq_i=01 -> rsp_valid_o, err=0.
REQ-034 READ addr 0x000127, irq_i=01, avm_rdata_i=0xAE8 -> writes (0x1,0),(0x2,0x127),(0x6,0x2), read 0x4, rsp_data_o=0xAE8.
REQ-035 avm_waitrequest_i high 3 cycles on ADDR_LO write -> write held 4 cycles, addr/data stable, sequence resumes.
REQ-036 TIMEOUT_CYCLES=16, irq_i stays 0 -> rsp_err_o=1 exactly 16 cycles after WAIT_IRQ entry; irq_i=11 -> err=1 next cycle.
REQ-037 Op 3 -> rsp err=1 one cycle after accept, no avm strobes; rst_i in WR_CMD -> strobes 0, no response, req_ready_o=1 after reset.
